// File: rtl/clb_config_loader.sv
// clb_config_loader: assembles per-CLB configuration words from a serial
// bitstream into a shadow buffer and verifies a trailing XOR checksum word.
// If the checksum matches, the shadow is committed to the live sram_bits bus.
// The CLB fabric is held in reset until a verified configuration is live, and
// also while a new load is being shifted in or checked.
module clb_config_loader #(
  parameter int NUM_CLB = 4,
  parameter int WORD_W  = 18
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      cfg_bit,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  output logic [NUM_CLB*WORD_W-1:0] sram_bits,
  output logic                      clb_reset,
  output logic                      config_done,
  output logic                      config_error
);

  localparam int BC_W = $clog2(WORD_W);
  localparam int WI_W = $clog2(NUM_CLB + 1);

  // Bit index of the last bit in a word, and the word index of the checksum
  // word, which follows the NUM_CLB data words.
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WORD_W - 1);
  localparam logic [WI_W-1:0] CHK_IDX  = WI_W'(NUM_CLB);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SHIFT = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERROR = 3'd4;

  logic [2:0]                state, state_nx;
  logic [BC_W-1:0]           bit_cnt;
  logic [WI_W-1:0]           word_idx;
  logic [WORD_W-2:0]         word_sr;
  logic [WORD_W-1:0]         word_nx;
  logic [WORD_W-1:0]         chk;
  logic [WORD_W-1:0]         rx_chk;
  logic [NUM_CLB*WORD_W-1:0] shadow;
  logic                      loaded, loaded_nx;
  logic                      restart, accept, word_end, commit;

  // The word as it will look once the current bit is shifted in, MSB first.
  assign word_nx = {word_sr, cfg_bit};

  // A start pulse in CHECK is ignored; anywhere else it begins a fresh load.
  assign restart  = start && (state != CHECK);
  // start has priority over a data bit presented in the same cycle.
  assign accept   = (state == SHIFT) && cfg_ready && cfg_valid && !start;
  assign word_end = accept && (bit_cnt == LAST_BIT);
  assign commit   = (state == CHECK) && (rx_chk == chk);

  assign loaded_nx = loaded || commit;

  // Next-state selection for the load sequencer.
  always_comb begin
    // NOTE: assign a default to every always_comb output before any branch so
    // that no path leaves it unassigned, which would infer a latch.
    state_nx = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_nx = SHIFT;
      SHIFT: begin
        if (start) begin
          state_nx = SHIFT;
        end else if (word_end && (word_idx == CHK_IDX)) begin
          state_nx = CHECK;
        end
      end
      CHECK:   state_nx = (rx_chk == chk) ? DONE : ERROR;
      default: state_nx = IDLE;
    endcase
  end

  // Sequencer state, bit/word counters, running checksum and registered outputs.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register in
    // this block samples the pre-edge values, independent of statement order.
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      word_idx     <= '0;
      word_sr      <= '0;
      chk          <= '0;
      rx_chk       <= '0;
      loaded       <= 1'b0;
      cfg_ready    <= 1'b0;
      sram_bits    <= '0;
      clb_reset    <= 1'b1;
      config_done  <= 1'b0;
      config_error <= 1'b0;
    end else begin
      state     <= state_nx;
      loaded    <= loaded_nx;
      cfg_ready <= (state_nx == SHIFT);
      clb_reset <= (state_nx == SHIFT) || (state_nx == CHECK) || !loaded_nx;

      if (restart) begin
        bit_cnt      <= '0;
        word_idx     <= '0;
        chk          <= '0;
        config_done  <= 1'b0;
        config_error <= 1'b0;
      end else if (accept) begin
        word_sr <= word_nx[WORD_W-2:0];
        if (bit_cnt == LAST_BIT) begin
          bit_cnt <= '0;
          if (word_idx == CHK_IDX) begin
            rx_chk <= word_nx;
          end else begin
            chk      <= chk ^ word_nx;
            word_idx <= word_idx + 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (state == CHECK) begin
        if (commit) begin
          sram_bits   <= shadow;
          config_done <= 1'b1;
        end else begin
          config_error <= 1'b1;
        end
      end
    end
  end

  // Shadow buffer: each completed data word lands in its CLB slot.
  always_ff @(posedge clock) begin
    // NOTE: the shadow is deliberately not reset; it is only observable through
    // a checksum-verified commit, which always follows a full rewrite of it.
    if (word_end && (word_idx != CHK_IDX)) begin
      shadow[int'(word_idx)*WORD_W +: WORD_W] <= word_nx;
    end
  end

endmodule

// File: tb/tb_clb_config_loader.sv
// Self-checking bench for clb_config_loader with NUM_CLB=2: a table of full
// load streams with hand-computed results, followed by hand-written sequences
// for start/valid collision, abort, trailing extra bits and mid-load reset.
module tb_clb_config_loader;

  localparam int NUM_CLB = 2;
  localparam int WORD_W  = 18;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      start;
  logic                      cfg_bit;
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [NUM_CLB*WORD_W-1:0] sram_bits;
  logic                      clb_reset;
  logic                      config_done;
  logic                      config_error;

  int checks = 0;
  int errors = 0;

  clb_config_loader #(
    .NUM_CLB (NUM_CLB),
    .WORD_W  (WORD_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .cfg_bit      (cfg_bit),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .sram_bits    (sram_bits),
    .clb_reset    (clb_reset),
    .config_done  (config_done),
    .config_error (config_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [17:0] w0;
    logic [17:0] w1;
    logic [17:0] c;
    bit          gap;
    logic [35:0] exp_sram;
    bit          exp_done;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one bit and hold it until the edge that accepts it; returns #1
  // after that edge with cfg_valid still high.
  task automatic send_bit(input logic b);
    int n;
    n = 0;
    cfg_bit   = b;
    cfg_valid = 1'b1;
    while (cfg_ready !== 1'b1 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: cfg_ready=%b after %0d cycles, expected 1", cfg_ready, n);
    end
    @(posedge clock); #1;
  endtask

  // Two data words and a checksum, MSB first; with gap set, cfg_valid drops
  // for two cycles between consecutive bits.
  task automatic send_stream(input logic [17:0] w0, input logic [17:0] w1,
                             input logic [17:0] c, input bit gap);
    logic [17:0] w;
    for (int k = 0; k < 3; k++) begin
      w = (k == 0) ? w0 : (k == 1) ? w1 : c;
      for (int i = 17; i >= 0; i--) begin
        if (gap && !(k == 0 && i == 17)) begin
          cfg_valid = 1'b0;
          repeat (2) begin @(posedge clock); #1; end
        end
        send_bit(w[i]);
      end
    end
  endtask

  task automatic pulse_start(input logic with_valid);
    start     = 1'b1;
    cfg_valid = with_valid;
    cfg_bit   = 1'b1;
    @(posedge clock); #1;
    start     = 1'b0;
    cfg_valid = 1'b0;
  endtask

  logic [35:0] prev_sram;

  initial begin
    vecs[0] = '{18'h2AAAA, 18'h15555, 18'h3FFFF, 1'b0, {18'h15555, 18'h2AAAA}, 1'b1};
    vecs[1] = '{18'h00001, 18'h00002, 18'h00000, 1'b0, {18'h15555, 18'h2AAAA}, 1'b0};
    vecs[2] = '{18'h2AAAA, 18'h15555, 18'h3FFFF, 1'b1, {18'h15555, 18'h2AAAA}, 1'b1};
    vecs[3] = '{18'h12345, 18'h3C0F0, 18'h2E3B5, 1'b0, {18'h3C0F0, 18'h12345}, 1'b1};
    vecs[4] = '{18'h3FFFF, 18'h3FFFF, 18'h00001, 1'b1, {18'h3C0F0, 18'h12345}, 1'b0};

    reset     = 1'b1;
    start     = 1'b0;
    cfg_bit   = 1'b0;
    cfg_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_sram", sram_bits, 0);
    check("rst_ready", cfg_ready, 0);
    check("rst_done", config_done, 0);
    check("rst_error", config_error, 0);
    check("rst_clb_reset", clb_reset, 1);
    reset = 1'b0;
    @(posedge clock); #1;
    check("idle_clb_reset", clb_reset, 1);

    // Table of complete loads; live state carries from one entry to the next.
    prev_sram = '0;
    for (int i = 0; i < 5; i++) begin
      pulse_start(1'b0);
      check($sformatf("v%0d_ready_shift", i), cfg_ready, 1);
      check($sformatf("v%0d_flags_cleared", i), {config_done, config_error}, 2'b00);
      check($sformatf("v%0d_clb_reset_shift", i), clb_reset, 1);
      send_stream(vecs[i].w0, vecs[i].w1, vecs[i].c, vecs[i].gap);
      cfg_valid = 1'b0;
      // In CHECK: nothing committed yet.
      check($sformatf("v%0d_ready_check", i), cfg_ready, 0);
      check($sformatf("v%0d_done_check", i), config_done, 0);
      check($sformatf("v%0d_sram_check", i), sram_bits, prev_sram);
      @(posedge clock); #1;
      check($sformatf("v%0d_done", i), config_done, vecs[i].exp_done);
      check($sformatf("v%0d_error", i), config_error, !vecs[i].exp_done);
      check($sformatf("v%0d_sram", i), sram_bits, vecs[i].exp_sram);
      check($sformatf("v%0d_clb_reset", i), clb_reset, 0);
      check($sformatf("v%0d_ready_end", i), cfg_ready, 0);
      prev_sram = vecs[i].exp_sram;
    end

    // start together with cfg_valid from ERROR: that bit must not be taken.
    pulse_start(1'b1);
    send_stream(18'h2AAAA, 18'h15555, 18'h3FFFF, 1'b0);
    cfg_valid = 1'b0;
    @(posedge clock); #1;
    check("sv_done", config_done, 1);
    check("sv_sram", sram_bits, {18'h15555, 18'h2AAAA});

    // Abort: 10 bits, then restart and send a full good stream.
    pulse_start(1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    cfg_valid = 1'b0;
    pulse_start(1'b0);
    check("abort_ready", cfg_ready, 1);
    send_stream(18'h12345, 18'h3C0F0, 18'h2E3B5, 1'b0);
    cfg_valid = 1'b0;
    @(posedge clock); #1;
    check("abort_done", config_done, 1);
    check("abort_error", config_error, 0);
    check("abort_sram", sram_bits, {18'h3C0F0, 18'h12345});

    // Extra bits after the checksum with cfg_valid held high.
    pulse_start(1'b0);
    send_stream(18'h2AAAA, 18'h15555, 18'h3FFFF, 1'b0);
    cfg_bit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("extra%0d_ready", i), cfg_ready, 0);
      @(posedge clock); #1;
    end
    cfg_valid = 1'b0;
    check("extra_done", config_done, 1);
    check("extra_error", config_error, 0);
    check("extra_sram", sram_bits, {18'h15555, 18'h2AAAA});
    check("extra_clb_reset", clb_reset, 0);

    // Reset after word 0 of a new load clears the live configuration.
    pulse_start(1'b0);
    for (int i = 17; i >= 0; i--) send_bit(1'b1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset     = 1'b0;
    cfg_valid = 1'b0;
    check("mid_rst_sram", sram_bits, 0);
    check("mid_rst_ready", cfg_ready, 0);
    check("mid_rst_done", config_done, 0);
    check("mid_rst_error", config_error, 0);
    check("mid_rst_clb_reset", clb_reset, 1);

    // Recovery after reset.
    pulse_start(1'b0);
    send_stream(18'h2AAAA, 18'h15555, 18'h3FFFF, 1'b0);
    cfg_valid = 1'b0;
    @(posedge clock); #1;
    check("recover_done", config_done, 1);
    check("recover_sram", sram_bits, {18'h15555, 18'h2AAAA});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
